// File: rtl/lgn_frame_sequencer.sv
// lgn_frame_sequencer: drives one stored test image from a synchronous ROM into the
//   LGN inference core byte by byte under a load strobe, waits for the network to
//   settle, then captures and holds the predicted class and score for display.
// Ports: clk/rst (sync, active high); start (level, edge-detected), auto_mode;
//   rom_addr/rom_data (1-cycle read latency); core_data/core_load to the core;
//   core_index/core_value from the core; result_* latched outputs; done (CAPTURE
//   pulse); busy (PRIME..CAPTURE); frame_sel (frame used by the next run).
module lgn_frame_sequencer #(
  parameter int BYTES_PER_FRAME = 98,
  parameter int NUM_FRAMES      = 4,
  parameter int SETTLE_CYCLES   = 16,
  parameter int HOLD_CYCLES     = 12000000,
  parameter int ADDR_W          = 9,
  localparam int FS_W           = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              auto_mode,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        core_data,
  output logic              core_load,
  input  logic [3:0]        core_index,
  input  logic [7:0]        core_value,
  output logic [3:0]        result_index,
  output logic [7:0]        result_value,
  output logic              result_valid,
  output logic              result_err,
  output logic              done,
  output logic              busy,
  output logic [FS_W-1:0]   frame_sel
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PRIME   = 3'd1;
  localparam logic [2:0] S_STREAM  = 3'd2;
  localparam logic [2:0] S_SETTLE  = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;

  // One counter serves the stream, settle and hold phases; size it for the longest.
  localparam int MAX_BS  = (BYTES_PER_FRAME > SETTLE_CYCLES) ? BYTES_PER_FRAME : SETTLE_CYCLES;
  localparam int CNT_MAX = (HOLD_CYCLES > MAX_BS) ? HOLD_CYCLES : MAX_BS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] BYTE_LAST   = CNT_W'(BYTES_PER_FRAME - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [FS_W-1:0]  FRAME_LAST  = FS_W'(NUM_FRAMES - 1);

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              start_q;
  logic              start_edge;
  logic [ADDR_W-1:0] base;

  assign start_edge = start & ~start_q;
  assign base       = ADDR_W'(frame_sel * BYTES_PER_FRAME);

  // The ROM answers one cycle late: PRIME presents byte 0's address so that byte k
  // arrives in stream cycle k, while stream cycle k already requests byte k+1.
  always_comb begin
    rom_addr = '0;
    if (state == S_PRIME) begin
      rom_addr = base;
    end else if (state == S_STREAM) begin
      rom_addr = base + ADDR_W'(cnt) + ADDR_W'(1);
    end
  end

  assign core_load = (state == S_STREAM);
  // Gate the data bus so the core never sees stale ROM output outside a load.
  assign core_data = core_load ? rom_data : 8'h00;
  assign done      = (state == S_CAPTURE);
  assign busy      = (state == S_PRIME) || (state == S_STREAM) ||
                     (state == S_SETTLE) || (state == S_CAPTURE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      start_q      <= 1'b0;
      frame_sel    <= '0;
      result_index <= 4'h0;
      result_value <= 8'h00;
      result_valid <= 1'b0;
      result_err   <= 1'b0;
    end else begin
      start_q <= start;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start_edge || auto_mode) begin
            state <= S_PRIME;
          end
        end
        S_PRIME: begin
          cnt          <= '0;
          result_valid <= 1'b0;
          state        <= S_STREAM;
        end
        S_STREAM: begin
          if (cnt == BYTE_LAST) begin
            cnt   <= '0;
            state <= S_SETTLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= S_CAPTURE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          // Out-of-range class indices are flagged and shown as blank (F).
          result_index <= (core_index > 4'd9) ? 4'hF : core_index;
          result_err   <= (core_index > 4'd9);
          result_value <= core_value;
          result_valid <= 1'b1;
          frame_sel    <= (frame_sel == FRAME_LAST) ? '0 : frame_sel + FS_W'(1);
          cnt          <= '0;
          state        <= S_HOLD;
        end
        S_HOLD: begin
          if (!auto_mode) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            state <= S_PRIME;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lgn_frame_sequencer.sv
// tb_lgn_frame_sequencer: directed bench for the frame sequencer with a synchronous
//   ROM model (byte at address n holds n mod 256) and a static core result model.
// Ports: none; drives the DUT on falling edges and samples just before driving.
module tb_lgn_frame_sequencer;

  localparam int BPF  = 98;
  localparam int NF   = 4;
  localparam int SET  = 16;
  localparam int HOLD = 20;
  localparam int AW   = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          auto_mode;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [7:0]    core_data;
  logic          core_load;
  logic [3:0]    core_index;
  logic [7:0]    core_value;
  logic [3:0]    result_index;
  logic [7:0]    result_value;
  logic          result_valid;
  logic          result_err;
  logic          done;
  logic          busy;
  logic [1:0]    frame_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Synchronous image ROM: data for an address appears one cycle later.
  always_ff @(posedge clk) rom_data <= rom_addr[7:0];

  lgn_frame_sequencer #(
    .BYTES_PER_FRAME(BPF), .NUM_FRAMES(NF), .SETTLE_CYCLES(SET),
    .HOLD_CYCLES(HOLD), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .auto_mode(auto_mode),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .core_data(core_data), .core_load(core_load),
    .core_index(core_index), .core_value(core_value),
    .result_index(result_index), .result_value(result_value),
    .result_valid(result_valid), .result_err(result_err),
    .done(done), .busy(busy), .frame_sel(frame_sel)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One manual run from IDLE. Cycle 1 after the edge-detect cycle is PRIME; done
  // lands in cycle 1+1+98+16 = 116 counted from the edge-detect cycle.
  task automatic run_frame(input int fidx, input logic [3:0] idx, input logic [7:0] val);
    int loads;
    int bad;
    int done_at;
    int ndone;
    logic [AW-1:0] addr0;
    loads = 0; bad = 0; done_at = -1; ndone = 0; addr0 = '0;
    core_index = idx;
    core_value = val;
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 300 && done_at < 0; i++) begin
      @(negedge clk);
      if (i == 1) addr0 = rom_addr;
      if (core_load) begin
        if (core_data != 8'((fidx * BPF + loads) & 255)) bad++;
        loads++;
      end else if (core_data != 8'h00) begin
        bad++;
      end
      if (done) begin
        done_at = i;
        ndone++;
      end
    end
    start = 1'b0;
    chk("load_cnt", 64'(loads), 64'(BPF));
    chk("data_order", 64'(bad), 64'd0);
    chk("done_latency", 64'(done_at), 64'd116);
    chk("prime_addr", 64'(addr0), 64'(fidx * BPF));
    @(negedge clk);
  endtask

  int ndone;
  int nload;
  int done1;
  int done2;
  int prime2;
  logic busy_prev;

  initial begin
    rst = 1'b1; start = 1'b0; auto_mode = 1'b0;
    core_index = 4'h0; core_value = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_out_a", {rom_addr, core_data, core_load, done, busy, frame_sel}, 64'd0);
    chk("rst_out_b", {result_index, result_value, result_valid, result_err}, 64'd0);
    rst = 1'b0;

    // Four manual runs through every frame, with in-range, out-of-range and edge indices.
    run_frame(0, 4'd7, 8'hA5);
    chk("r1_index", 64'(result_index), 64'd7);
    chk("r1_value", 64'(result_value), 64'hA5);
    chk("r1_valid", 64'(result_valid), 64'd1);
    chk("r1_err", 64'(result_err), 64'd0);
    chk("r1_frame", 64'(frame_sel), 64'd1);

    run_frame(1, 4'd12, 8'h3C);
    chk("r2_index", 64'(result_index), 64'hF);
    chk("r2_err", 64'(result_err), 64'd1);
    chk("r2_value", 64'(result_value), 64'h3C);
    chk("r2_frame", 64'(frame_sel), 64'd2);

    run_frame(2, 4'd10, 8'h01);
    chk("r3_index", 64'(result_index), 64'hF);
    chk("r3_frame", 64'(frame_sel), 64'd3);

    run_frame(3, 4'd9, 8'hFF);
    chk("r4_index", 64'(result_index), 64'd9);
    chk("r4_err", 64'(result_err), 64'd0);
    chk("r4_frame", 64'(frame_sel), 64'd0);

    // Start re-pulsed during STREAM must not queue a second run.
    ndone = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (done) ndone++;
      if (i == 20) start = 1'b0;
      if (i == 22) start = 1'b1;
      if (i == 25) start = 1'b0;
    end
    chk("repulse_done", 64'(ndone), 64'd1);
    chk("repulse_frame", 64'(frame_sel), 64'd1);

    // Reset in the middle of streaming: everything drops, no result kept.
    nload = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 200 && nload < 41; i++) begin
      @(negedge clk);
      if (core_load) nload++;
    end
    chk("abort_reached", 64'(nload), 64'd41);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("abort_out_a", {rom_addr, core_data, core_load, done, busy, frame_sel}, 64'd0);
    chk("abort_out_b", {result_index, result_value, result_valid, result_err}, 64'd0);
    rst = 1'b0;

    // Auto mode: PRIME follows done by HOLD+1 cycles; done-to-done is 21+115.
    done1 = -1; done2 = -1; prime2 = -1; busy_prev = 1'b0;
    core_index = 4'd2; core_value = 8'h55;
    @(negedge clk);
    auto_mode = 1'b1;
    for (int i = 1; i <= 400 && done2 < 0; i++) begin
      @(negedge clk);
      if (done && done1 < 0) done1 = i;
      else if (done) done2 = i;
      if (busy && !busy_prev && done1 >= 0 && prime2 < 0) prime2 = i;
      busy_prev = busy;
    end
    chk("auto_prime_gap", 64'(prime2 - done1), 64'd21);
    chk("auto_done_gap", 64'(done2 - done1), 64'd136);
    repeat (5) @(negedge clk);
    auto_mode = 1'b0;
    nload = 0; ndone = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (core_load || busy) nload++;
      if (done) ndone++;
    end
    chk("auto_stop_act", 64'(nload), 64'd0);
    chk("auto_stop_done", 64'(ndone), 64'd0);
    chk("auto_frame", 64'(frame_sel), 64'd2);
    chk("auto_result", {result_index, result_value, result_valid}, {4'd2, 8'h55, 1'b1});

    // Start held high for 500 cycles yields exactly one run.
    ndone = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 500; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    start = 1'b0;
    chk("held_start_done", 64'(ndone), 64'd1);
    chk("held_frame", 64'(frame_sel), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
